me_block_scheduler: RTL and testbench

Frame-level sequencer for the motion-estimation datapath. It walks a frame's macroblocks in raster order and drives the current-block buffer's `en`/`next_block` controls. For each block it waits a fixed load time, then triggers the SAD search engine and captures its result. Each block's motion vector is presented to the downstream consumer over a valid/ready handshake, and the scheduler only moves to the next block after that vector is accepted.

---
 rtl/me_pkg.sv | 23 ++
 rtl/me_blk_raster_cnt.sv | 54 +++++
 rtl/me_block_scheduler.sv | 168 ++++++++++++++++
 tb/tb_me_block_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation control blocks.
package me_pkg;

    // Block scheduler states; IDLE is encoded as zero so reset reads as all-zero.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4,
        ST_DONE   = 3'd5
    } me_state_e;

    // Signed motion-vector component width.
    localparam int ME_MVW = 8;
    // Width of a sum-of-absolute-differences result.
    localparam int ME_SADW = 16;
    // Current-block buffer fill time: 512 bits at 32 bits per cycle.
    localparam int ME_LOAD_CYCLES = 16;
    // Width of the block coordinate counters.
    localparam int ME_CW = 8;

endpackage

// File: rtl/me_blk_raster_cnt.sv
// Raster-order macroblock coordinate counter (x fastest, then y).
// Shared between the block scheduler and the reference-window fetcher.
module me_blk_raster_cnt #(
    parameter int W_BLK = 4,
    parameter int H_BLK = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          last_o
);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          x_at_end;

    assign x_at_end = (x_q == CW'(W_BLK - 1));
    assign last_o   = x_at_end && (y_q == CW'(H_BLK - 1));
    assign x_o      = x_q;
    assign y_o      = y_q;

    // Next coordinate: clear wins over advance; x wraps into a y step.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/me_block_scheduler.sv
// Frame-level sequencer: walks macroblocks in raster order, paces the
// current-block buffer, triggers the SAD search and hands each result on.
//
// Result handshake: mv_valid is raised in OUT and every mv_* output is held
// constant until the cycle where mv_valid && mv_ready are both high; that
// edge is the transfer. mv_ready while mv_valid is low has no effect.
module me_block_scheduler
    import me_pkg::*;
#(
    parameter int FRAME_W_BLK = 4,
    parameter int FRAME_H_BLK = 4,
    parameter int LOAD_CYCLES = ME_LOAD_CYCLES,
    parameter int CW          = ME_CW,
    parameter int MVW         = ME_MVW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  cur_en,
    output logic                  next_block,
    output logic                  sad_start,
    input  logic                  sad_done,
    input  logic signed [MVW-1:0] sad_mv_x,
    input  logic signed [MVW-1:0] sad_mv_y,
    input  logic [ME_SADW-1:0]    sad_min,
    output logic                  mv_valid,
    input  logic                  mv_ready,
    output logic signed [MVW-1:0] mv_x,
    output logic signed [MVW-1:0] mv_y,
    output logic [ME_SADW-1:0]    mv_sad,
    output logic [CW-1:0]         mv_blk_x,
    output logic [CW-1:0]         mv_blk_y,
    output logic                  busy,
    output logic                  frame_done,
    output me_state_e             dbg_state_o
);

    localparam int LCW = $clog2(LOAD_CYCLES + 1);

    me_state_e             state_q, state_d;
    logic [LCW-1:0]        load_cnt_q, load_cnt_d;
    logic                  first_blk_q, first_blk_d;
    logic signed [MVW-1:0] mv_x_q, mv_x_d;
    logic signed [MVW-1:0] mv_y_q, mv_y_d;
    logic [ME_SADW-1:0]    mv_sad_q, mv_sad_d;
    logic [CW-1:0]         mv_blk_x_q, mv_blk_x_d;
    logic [CW-1:0]         mv_blk_y_q, mv_blk_y_d;

    logic                  cnt_clr, cnt_adv, blk_last, load_end;
    logic [CW-1:0]         blk_x, blk_y;

    me_blk_raster_cnt #(
        .W_BLK (FRAME_W_BLK),
        .H_BLK (FRAME_H_BLK),
        .CW    (CW)
    ) u_raster (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .x_o    (blk_x),
        .y_o    (blk_y),
        .last_o (blk_last)
    );

    assign load_end = (load_cnt_q == LCW'(LOAD_CYCLES - 1));

    // Next-state, load counter and result capture.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        first_blk_d = first_blk_q;
        mv_x_d      = mv_x_q;
        mv_y_d      = mv_y_q;
        mv_sad_d    = mv_sad_q;
        mv_blk_x_d  = mv_blk_x_q;
        mv_blk_y_d  = mv_blk_y_q;
        cnt_clr     = 1'b0;
        cnt_adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    load_cnt_d  = '0;
                    first_blk_d = 1'b1;
                    cnt_clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_end) begin
                    state_d    = ST_SEARCH;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_SEARCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sad_done) begin
                    mv_x_d     = sad_mv_x;
                    mv_y_d     = sad_mv_y;
                    mv_sad_d   = sad_min;
                    mv_blk_x_d = blk_x;
                    mv_blk_y_d = blk_y;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (mv_ready) begin
                    first_blk_d = 1'b0;
                    if (blk_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_adv    = 1'b1;
                        load_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            first_blk_q <= 1'b0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            mv_sad_q    <= '0;
            mv_blk_x_q  <= '0;
            mv_blk_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            first_blk_q <= first_blk_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
            mv_sad_q    <= mv_sad_d;
            mv_blk_x_q  <= mv_blk_x_d;
            mv_blk_y_q  <= mv_blk_y_d;
        end
    end

    // Block 0 is fetched on the rising cur_en, so only later blocks request a load.
    assign next_block  = (state_q == ST_LOAD) && (load_cnt_q == '0) && !first_blk_q;
    assign cur_en      = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign sad_start   = (state_q == ST_SEARCH);
    assign mv_valid    = (state_q == ST_OUT);
    assign frame_done  = (state_q == ST_DONE);
    assign mv_x        = mv_x_q;
    assign mv_y        = mv_y_q;
    assign mv_sad      = mv_sad_q;
    assign mv_blk_x    = mv_blk_x_q;
    assign mv_blk_y    = mv_blk_y_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_me_block_scheduler.sv
// Bench for me_block_scheduler: a 2x2 frame instance driven by a search-engine
// model and a scoreboard, plus a 1x1 frame instance driven directly.
module tb_me_block_scheduler;
    import me_pkg::*;

    localparam int W    = 2;
    localparam int H    = 2;
    localparam int L    = 16;
    localparam int CW   = 8;
    localparam int MVW  = 8;
    localparam int SW   = 16;
    localparam int EXPW = 2 * CW + 2 * MVW + SW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- 2x2 instance ----------------
    logic           start, sad_done, mv_ready;
    logic [MVW-1:0] sad_mv_x, sad_mv_y, mv_x, mv_y;
    logic [SW-1:0]  sad_min, mv_sad;
    logic           cur_en, next_block, sad_start, mv_valid, busy, frame_done;
    logic [CW-1:0]  mv_blk_x, mv_blk_y;
    me_state_e      dbg_state;

    me_block_scheduler #(
        .FRAME_W_BLK (W), .FRAME_H_BLK (H), .LOAD_CYCLES (L), .CW (CW), .MVW (MVW)
    ) dut (
        .clk (clk), .rst (rst_n), .start (start),
        .cur_en (cur_en), .next_block (next_block), .sad_start (sad_start),
        .sad_done (sad_done), .sad_mv_x (sad_mv_x), .sad_mv_y (sad_mv_y), .sad_min (sad_min),
        .mv_valid (mv_valid), .mv_ready (mv_ready), .mv_x (mv_x), .mv_y (mv_y), .mv_sad (mv_sad),
        .mv_blk_x (mv_blk_x), .mv_blk_y (mv_blk_y), .busy (busy), .frame_done (frame_done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- 1x1 instance ----------------
    logic           start_b, sad_done_b, mv_ready_b;
    logic [MVW-1:0] sad_mv_x_b, sad_mv_y_b, mv_x_b, mv_y_b;
    logic [SW-1:0]  sad_min_b, mv_sad_b;
    logic           cur_en_b, next_block_b, sad_start_b, mv_valid_b, busy_b, frame_done_b;
    logic [CW-1:0]  mv_blk_x_b, mv_blk_y_b;
    me_state_e      dbg_state_b;

    me_block_scheduler #(
        .FRAME_W_BLK (1), .FRAME_H_BLK (1), .LOAD_CYCLES (L), .CW (CW), .MVW (MVW)
    ) dut_b (
        .clk (clk), .rst (rst_n), .start (start_b),
        .cur_en (cur_en_b), .next_block (next_block_b), .sad_start (sad_start_b),
        .sad_done (sad_done_b), .sad_mv_x (sad_mv_x_b), .sad_mv_y (sad_mv_y_b), .sad_min (sad_min_b),
        .mv_valid (mv_valid_b), .mv_ready (mv_ready_b), .mv_x (mv_x_b), .mv_y (mv_y_b), .mv_sad (mv_sad_b),
        .mv_blk_x (mv_blk_x_b), .mv_blk_y (mv_blk_y_b), .busy (busy_b), .frame_done (frame_done_b),
        .dbg_state_o (dbg_state_b)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXPW-1:0] exp_q[$];

    int eng_delay = 3;    // search latency in cycles after sad_start
    bit sad_fixed = 1'b1; // 1: SAD result is 0x0040, else random
    int spur_req  = 0;    // bump to request one spurious sad_done
    int spur_ack  = 0;
    int model_idx = 0;    // raster index of the block being searched
    int nb_cnt = 0, ss_cnt = 0, fd_cnt = 0, pop_cnt = 0, nb_b_cnt = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- search engine model + expected-result producer ----------------
    initial begin : engine
        int cnt, bx, by;
        bit prev_busy;
        logic [SW-1:0] s;
        cnt = 0;
        prev_busy = 1'b0;
        sad_done = 1'b0;
        sad_mv_x = '0;
        sad_mv_y = '0;
        sad_min  = '0;
        forever begin
            @(negedge clk);
            sad_done = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                prev_busy = 1'b0;
                spur_ack = spur_req;
            end else begin
                if (busy && !prev_busy) model_idx = 0;
                prev_busy = busy;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bx = model_idx % W;
                        by = model_idx / W;
                        s  = sad_fixed ? 16'h0040 : SW'($urandom_range(0, 65535));
                        sad_done = 1'b1;
                        sad_mv_x = MVW'(bx + 1);
                        sad_mv_y = MVW'(-by);
                        sad_min  = s;
                        exp_q.push_back({CW'(bx), CW'(by), sad_mv_x, sad_mv_y, s});
                        model_idx++;
                    end
                end else if (spur_req != spur_ack) begin
                    spur_ack = spur_req;
                    sad_done = 1'b1;
                    sad_mv_x = 8'h55;
                    sad_mv_y = 8'h66;
                    sad_min  = 16'hdead;
                end
                if (sad_start) cnt = eng_delay;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [EXPW-1:0] exp, act, prev_out;
        bit stall, nb_due;
        int after_last;
        stall = 1'b0;
        nb_due = 1'b0;
        after_last = 0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            act = {mv_blk_x, mv_blk_y, mv_x, mv_y, mv_sad};
            if (!rst_n) begin
                exp_q.delete();
                stall = 1'b0;
                nb_due = 1'b0;
                after_last = 0;
            end else begin
                nb_cnt += int'(next_block);
                ss_cnt += int'(sad_start);
                fd_cnt += int'(frame_done);
                if (nb_due) begin
                    check_eq("next_block_after_handshake", next_block, 1);
                    nb_due = 1'b0;
                end
                if (after_last == 1) begin
                    check_eq("frame_done_after_last", frame_done, 1);
                    after_last = 2;
                end else if (after_last == 2) begin
                    check_eq("idle_two_after_last", {cur_en, busy}, 0);
                    after_last = 0;
                end
                if (stall) check_eq("mv_hold_under_backpressure", {mv_valid, act}, {1'b1, prev_out});
                stall = mv_valid && !mv_ready;
                prev_out = act;
                if (mv_valid && mv_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("result_without_expectation", act, '1);
                    end else begin
                        exp = exp_q.pop_front();
                        check_eq("mv_result", act, exp);
                        pop_cnt++;
                        if (exp[EXPW-1 -: CW] == CW'(W - 1) && exp[EXPW-CW-1 -: CW] == CW'(H - 1))
                            after_last = 1;
                        else
                            nb_due = 1'b1;
                    end
                end
            end
        end
    end

    // 1x1 next_block counter.
    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (rst_n) nb_b_cnt += int'(next_block_b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_start(input bit spur);
        int lat, nb0;
        nb0 = nb_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        if (spur) spur_req++;
        check_eq("start_cur_en", cur_en, 1);
        check_eq("start_state_load", dbg_state, ST_LOAD);
        lat = 1;
        while (!sad_start && lat < 100) begin
            step();
            lat++;
        end
        check_eq("start_to_sad_start_latency", lat, L + 1);
        check_eq("no_next_block_first_block", nb_cnt - nb0, 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!mv_valid && n < 200) begin
            step();
            n++;
        end
        check_eq(name, mv_valid, 1);
    endtask

    task automatic finish_frame(input int fd0, input bit rnd);
        int n = 0;
        while (fd_cnt == fd0 && n < 3000) begin
            if (rnd) begin
                mv_ready  = 1'($urandom_range(0, 1));
                eng_delay = $urandom_range(1, 6);
            end
            step();
            n++;
        end
        check_eq("frame_done_count", fd_cnt - fd0, 1);
        step();
        step();
        check_eq("idle_after_frame", {cur_en, busy, dbg_state}, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int nb0, fd0, pc0, ss0, n, lat;
        logic [MVW-1:0] ex_x, ex_y;
        logic [SW-1:0]  ex_s;
        rst_n = 1'b0;
        start = 1'b0;
        mv_ready = 1'b0;
        start_b = 1'b0;
        sad_done_b = 1'b0;
        sad_mv_x_b = '0;
        sad_mv_y_b = '0;
        sad_min_b = '0;
        mv_ready_b = 1'b0;
        repeat (3) step();

        // Reset values.
        check_eq("reset_ctrl", {cur_en, next_block, sad_start, mv_valid, busy, frame_done}, 0);
        check_eq("reset_mv", {mv_blk_x, mv_blk_y, mv_x, mv_y, mv_sad}, 0);
        check_eq("reset_state", dbg_state, ST_IDLE);
        check_eq("reset_1x1", {cur_en_b, next_block_b, sad_start_b, mv_valid_b, busy_b, frame_done_b,
                               mv_blk_x_b, mv_blk_y_b, mv_x_b, mv_y_b, mv_sad_b}, 0);
        rst_n = 1'b1;
        while ($time < 96) step();
        #4;

        // Frame 1: full frame, ready tied high, fixed SAD.
        mv_ready = 1'b1;
        sad_fixed = 1'b1;
        eng_delay = 3;
        nb0 = nb_cnt; fd0 = fd_cnt; pc0 = pop_cnt;
        run_start(1'b0);
        finish_frame(fd0, 1'b0);
        check_eq("f1_results", pop_cnt - pc0, 4);
        check_eq("f1_next_block_pulses", nb_cnt - nb0, 3);

        // Frame 2: spurious sad_done in LOAD, spurious start in WAIT, back-pressure on (1,0).
        mv_ready = 1'b0;
        sad_fixed = 1'b0;
        eng_delay = 3;
        nb0 = nb_cnt; fd0 = fd_cnt; pc0 = pop_cnt;
        run_start(1'b1);
        step();
        check_eq("f2_in_wait", dbg_state, ST_WAIT);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("f2_valid_blk0");
        mv_ready = 1'b1;
        step();
        mv_ready = 1'b0;
        wait_valid("f2_valid_blk1");
        check_eq("f2_blk1_coords", {mv_blk_x, mv_blk_y}, {8'd1, 8'd0});
        ss0 = ss_cnt;
        n = nb_cnt;
        repeat (20) step();
        check_eq("bp_valid_held", mv_valid, 1);
        check_eq("bp_no_sad_start", ss_cnt - ss0, 0);
        check_eq("bp_no_next_block", nb_cnt - n, 0);
        check_eq("bp_cur_en", cur_en, 1);
        mv_ready = 1'b1;
        step();
        check_eq("bp_next_block_after_ready", next_block, 1);
        finish_frame(fd0, 1'b1);
        check_eq("f2_results", pop_cnt - pc0, 4);
        check_eq("f2_next_block_pulses", nb_cnt - nb0, 3);

        // Frame 3: asynchronous reset during WAIT of block (0,1).
        mv_ready = 1'b1;
        eng_delay = 6;
        ss0 = ss_cnt;
        run_start(1'b0);
        n = 0;
        while (!((ss_cnt - ss0) == 3 && dbg_state == ST_WAIT) && n < 300) begin
            step();
            n++;
        end
        check_eq("f3_reached_wait_blk2", dbg_state, ST_WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_ctrl", {cur_en, next_block, sad_start, mv_valid, busy, frame_done}, 0);
        check_eq("midreset_mv", {mv_blk_x, mv_blk_y, mv_x, mv_y, mv_sad}, 0);
        check_eq("midreset_state", dbg_state, ST_IDLE);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Frame 4: fresh frame after reset starts at (0,0) with random timing.
        eng_delay = 2;
        nb0 = nb_cnt; fd0 = fd_cnt; pc0 = pop_cnt;
        run_start(1'b0);
        finish_frame(fd0, 1'b1);
        check_eq("f4_results", pop_cnt - pc0, 4);
        check_eq("f4_next_block_pulses", nb_cnt - nb0, 3);

        // 1x1 frame on the second instance.
        ex_x = MVW'($urandom_range(0, 255));
        ex_y = MVW'($urandom_range(0, 255));
        ex_s = SW'($urandom_range(0, 65535));
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        lat = 1;
        while (!sad_start_b && lat < 100) begin
            step();
            lat++;
        end
        check_eq("b_latency", lat, L + 1);
        sad_done_b = 1'b1;           // in SEARCH: must be ignored
        sad_mv_x_b = 8'haa;
        sad_mv_y_b = 8'hbb;
        sad_min_b  = 16'hbeef;
        step();
        check_eq("b_first_wait", dbg_state_b, ST_WAIT);
        sad_mv_x_b = ex_x;           // first WAIT cycle: real result
        sad_mv_y_b = ex_y;
        sad_min_b  = ex_s;
        step();
        sad_done_b = 1'b0;
        check_eq("b_valid", mv_valid_b, 1);
        check_eq("b_result", {mv_blk_x_b, mv_blk_y_b, mv_x_b, mv_y_b, mv_sad_b},
                 {8'd0, 8'd0, ex_x, ex_y, ex_s});
        mv_ready_b = 1'b1;
        step();
        mv_ready_b = 1'b0;
        check_eq("b_frame_done", {frame_done_b, mv_valid_b}, 2'b10);
        step();
        check_eq("b_idle", {cur_en_b, busy_b, frame_done_b}, 0);
        check_eq("b_no_next_block", nb_b_cnt, 0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
